// File: rtl/line_mem_responder_if.sv
// Line interface between the permutation controller and the row memory:
// load stream, read/write request ports and drain stream grouped together.
interface line_mem_responder_if #(
  parameter int WIDTH = 25,
  parameter int IDXW  = 3
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             load_done;
  logic             rd_en;
  logic [IDXW-1:0]  rd_row;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             wr_en;
  logic [IDXW-1:0]  wr_row;
  logic [WIDTH-1:0] wr_data;
  logic             unload;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             out_last;
  logic             err;

  modport master (
    output in_valid, in_data, rd_en, rd_row, wr_en, wr_row, wr_data, unload, out_ready,
    input  in_ready, load_done, rd_data, rd_valid, out_valid, out_data, out_last, err
  );

  modport slave (
    input  in_valid, in_data, rd_en, rd_row, wr_en, wr_row, wr_data, unload, out_ready,
    output in_ready, load_done, rd_data, rd_valid, out_valid, out_data, out_last, err
  );
endinterface

// File: rtl/line_mem_responder.sv
// Row memory behind the controller's line interface: stream-in load, random
// read/write service window, then in-order stream-out drain.
module line_mem_responder #(
  parameter int ROWS  = 5,
  parameter int WIDTH = 25,
  parameter int IDXW  = 3
) (
  input logic                  clk,
  input logic                  rst,
  line_mem_responder_if.slave  bus
);

  typedef enum logic [1:0] {LOAD, SERVE, UNLOAD} state_t;

  localparam logic [IDXW-1:0] LAST_ROW = IDXW'(ROWS - 1);

  state_t           state, nextState;
  logic [IDXW-1:0]  ptr;
  logic [WIDTH-1:0] mem [ROWS];
  logic [WIDTH-1:0] rdData;
  logic             rdValid;
  logic             loadDone;
  logic             errFlag;
  logic             inReady;
  logic             outValid;
  logic             outLast;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= nextState;
  end

  // NOTE: every output gets a default first, so no path can infer a latch.
  always_comb begin
    nextState = state;
    inReady   = 1'b0;
    outValid  = 1'b0;
    outLast   = 1'b0;
    case (state)
      LOAD: begin
        inReady = 1'b1;
        if (bus.in_valid && ptr == LAST_ROW) nextState = SERVE;
      end
      SERVE: begin
        if (bus.unload) nextState = UNLOAD;
      end
      UNLOAD: begin
        outValid = 1'b1;
        outLast  = (ptr == LAST_ROW);
        if (bus.out_ready && outLast) nextState = LOAD;
      end
      default: nextState = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      rdData   <= '0;
      rdValid  <= 1'b0;
      loadDone <= 1'b0;
      errFlag  <= 1'b0;
      // NOTE: rows are cleared explicitly on reset, so the array must stay in flops.
      for (int i = 0; i < ROWS; i++) mem[i] <= '0;
    end else begin
      rdValid  <= 1'b0;
      loadDone <= 1'b0;
      case (state)
        LOAD: begin
          if (bus.rd_en || bus.wr_en) errFlag <= 1'b1;
          if (bus.in_valid) begin
            mem[ptr] <= bus.in_data;
            if (ptr == LAST_ROW) begin
              ptr      <= '0;
              loadDone <= 1'b1;
            end else begin
              ptr <= ptr + IDXW'(1);
            end
          end
        end
        SERVE: begin
          // Read samples the array before this edge's write lands: read-before-write.
          if (bus.rd_en) begin
            rdValid <= 1'b1;
            if (bus.rd_row <= LAST_ROW) begin
              rdData <= mem[bus.rd_row];
            end else begin
              rdData  <= '0;
              errFlag <= 1'b1;
            end
          end
          if (bus.wr_en) begin
            if (bus.wr_row <= LAST_ROW) mem[bus.wr_row] <= bus.wr_data;
            else                        errFlag         <= 1'b1;
          end
          if (bus.unload) ptr <= '0;
        end
        UNLOAD: begin
          if (bus.rd_en || bus.wr_en) errFlag <= 1'b1;
          if (bus.out_ready) begin
            if (ptr == LAST_ROW) ptr <= '0;
            else                 ptr <= ptr + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.load_done = loadDone;
  assign bus.rd_data   = rdData;
  assign bus.rd_valid  = rdValid;
  assign bus.out_valid = outValid;
  assign bus.out_data  = mem[ptr];
  assign bus.out_last  = outLast;
  assign bus.err       = errFlag;

endmodule

// File: tb/tb_line_mem_responder.sv
// Self-checking bench for line_mem_responder: directed load/serve/drain/reset
// sequences plus randomized traffic against a row-array reference model.
module tb_line_mem_responder;

  localparam int ROWS  = 5;
  localparam int WIDTH = 25;
  localparam int IDXW  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  line_mem_responder_if #(.WIDTH(WIDTH), .IDXW(IDXW)) bus ();

  line_mem_responder #(.ROWS(ROWS), .WIDTH(WIDTH), .IDXW(IDXW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int passCount  = 0;
  int checkCount = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  // Reference model: phase 0 = accepting load words, 1 = serving, 2 = draining.
  logic [WIDTH-1:0] refMem [ROWS];
  int               refPhase;
  int               refCount;
  bit               refErr;
  bit               expRdValid;
  logic [WIDTH-1:0] expRdData;
  bit               expLoadDone;

  task automatic modelEdge();
    expRdValid  = 1'b0;
    expLoadDone = 1'b0;
    if (rst) begin
      refPhase  = 0;
      refCount  = 0;
      refErr    = 1'b0;
      expRdData = '0;
      for (int i = 0; i < ROWS; i++) refMem[i] = '0;
      return;
    end
    case (refPhase)
      0: begin
        if (bus.rd_en || bus.wr_en) refErr = 1'b1;
        if (bus.in_valid) begin
          refMem[refCount] = bus.in_data;
          refCount++;
          if (refCount == ROWS) begin
            refCount    = 0;
            refPhase    = 1;
            expLoadDone = 1'b1;
          end
        end
      end
      1: begin
        if (bus.rd_en) begin
          expRdValid = 1'b1;
          if (int'(bus.rd_row) < ROWS) expRdData = refMem[bus.rd_row];
          else begin
            expRdData = '0;
            refErr    = 1'b1;
          end
        end
        if (bus.wr_en) begin
          if (int'(bus.wr_row) < ROWS) refMem[bus.wr_row] = bus.wr_data;
          else                         refErr             = 1'b1;
        end
        if (bus.unload) begin
          refPhase = 2;
          refCount = 0;
        end
      end
      default: begin
        if (bus.rd_en || bus.wr_en) refErr = 1'b1;
        if (bus.out_ready) begin
          refCount++;
          if (refCount == ROWS) begin
            refCount = 0;
            refPhase = 0;
          end
        end
      end
    endcase
  endtask

  task automatic checkModel();
    check("in_ready", bus.in_ready, refPhase == 0);
    check("out_valid", bus.out_valid, refPhase == 2);
    check("out_last", bus.out_last, refPhase == 2 && refCount == ROWS - 1);
    if (refPhase == 2) check("out_data", bus.out_data, refMem[refCount]);
    check("rd_valid", bus.rd_valid, expRdValid);
    check("rd_data", bus.rd_data, expRdData);
    check("load_done", bus.load_done, expLoadDone);
    check("err", bus.err, refErr);
  endtask

  task automatic tick();
    modelEdge();
    @(posedge clk);
    #1;
    checkModel();
  endtask

  task automatic setIdle();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.rd_en     = 1'b0;
    bus.rd_row    = '0;
    bus.wr_en     = 1'b0;
    bus.wr_row    = '0;
    bus.wr_data   = '0;
    bus.unload    = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  typedef struct {
    bit               rdEn;
    logic [IDXW-1:0]  rdRow;
    bit               wrEn;
    logic [IDXW-1:0]  wrRow;
    logic [WIDTH-1:0] wrData;
    bit               expValid;
    logic [WIDTH-1:0] expData;
    bit               expErr;
  } vec_t;

  vec_t             vecs [10];
  logic [WIDTH-1:0] loadWords [ROWS];
  logic [WIDTH-1:0] drainExp [ROWS];

  initial begin
    int k;
    bit ready;

    vecs[0] = '{1'b1, 3'd3, 1'b0, 3'd0, 25'h0,       1'b1, 25'h8,       1'b0};
    vecs[1] = '{1'b0, 3'd0, 1'b1, 3'd3, 25'h1ABCDEF, 1'b0, 25'h8,       1'b0};
    vecs[2] = '{1'b1, 3'd3, 1'b0, 3'd0, 25'h0,       1'b1, 25'h1ABCDEF, 1'b0};
    vecs[3] = '{1'b1, 3'd2, 1'b1, 3'd2, 25'h155,     1'b1, 25'h4,       1'b0};
    vecs[4] = '{1'b1, 3'd2, 1'b0, 3'd0, 25'h0,       1'b1, 25'h155,     1'b0};
    vecs[5] = '{1'b1, 3'd0, 1'b0, 3'd0, 25'h0,       1'b1, 25'h1,       1'b0};
    vecs[6] = '{1'b1, 3'd4, 1'b0, 3'd0, 25'h0,       1'b1, 25'h10,      1'b0};
    vecs[7] = '{1'b1, 3'd6, 1'b0, 3'd0, 25'h0,       1'b1, 25'h0,       1'b1};
    vecs[8] = '{1'b0, 3'd0, 1'b1, 3'd7, 25'h3,       1'b0, 25'h0,       1'b1};
    vecs[9] = '{1'b1, 3'd1, 1'b0, 3'd0, 25'h0,       1'b1, 25'h2,       1'b1};
    loadWords = '{25'h1, 25'h2, 25'h4, 25'h8, 25'h10};
    drainExp  = '{25'h1, 25'h2, 25'h155, 25'h1ABCDEF, 25'h10};

    setIdle();
    rst = 1'b1;
    tick();
    check("reset_in_ready", bus.in_ready, 1'b1);
    check("reset_rd_data", bus.rd_data, 25'h0);
    check("reset_err", bus.err, 1'b0);
    rst = 1'b0;

    // Load five rows with in_valid held high throughout.
    bus.in_valid = 1'b1;
    for (int i = 0; i < ROWS; i++) begin
      bus.in_data = loadWords[i];
      tick();
      check("load_done_pulse", bus.load_done, i == ROWS - 1);
    end
    check("in_ready_after_load", bus.in_ready, 1'b0);
    setIdle();

    for (int i = 0; i < 10; i++) begin
      bus.rd_en   = vecs[i].rdEn;
      bus.rd_row  = vecs[i].rdRow;
      bus.wr_en   = vecs[i].wrEn;
      bus.wr_row  = vecs[i].wrRow;
      bus.wr_data = vecs[i].wrData;
      tick();
      check($sformatf("vec%0d_rd_valid", i), bus.rd_valid, vecs[i].expValid);
      check($sformatf("vec%0d_rd_data", i), bus.rd_data, vecs[i].expData);
      check($sformatf("vec%0d_err", i), bus.err, vecs[i].expErr);
    end
    setIdle();

    // Drain with out_ready alternating 1,0,1,...; data must hold while stalled.
    bus.unload = 1'b1;
    tick();
    bus.unload = 1'b0;
    k = 0;
    ready = 1'b1;
    for (int c = 0; c < 20 && k < ROWS; c++) begin
      check($sformatf("drain%0d_data", k), bus.out_data, drainExp[k]);
      check($sformatf("drain%0d_last", k), bus.out_last, k == ROWS - 1);
      bus.out_ready = ready;
      tick();
      if (ready) k++;
      ready = ~ready;
    end
    check("drain_count", k, ROWS);
    check("in_ready_after_drain", bus.in_ready, 1'b1);
    check("err_sticky", bus.err, 1'b1);
    setIdle();

    // Reset mid-load, stray write during load, then a fresh load of zeros.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("err_cleared", bus.err, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 25'hAAAA;
    tick();
    bus.in_data  = 25'hBBBB;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midload_in_ready", bus.in_ready, 1'b1);
    bus.in_data = '0;
    for (int i = 0; i < ROWS - 1; i++) begin
      tick();
      check("reload_no_done", bus.load_done, 1'b0);
    end
    setIdle();
    bus.wr_en   = 1'b1;
    bus.wr_row  = 3'd0;
    bus.wr_data = 25'h777;
    tick();
    check("load_wr_err", bus.err, 1'b1);
    check("load_wr_no_done", bus.load_done, 1'b0);
    setIdle();
    bus.in_valid = 1'b1;
    tick();
    check("reload_done", bus.load_done, 1'b1);
    setIdle();
    for (int i = 0; i < ROWS; i++) begin
      bus.rd_en  = 1'b1;
      bus.rd_row = IDXW'(i);
      tick();
      check($sformatf("reload_row%0d", i), bus.rd_data, 25'h0);
    end
    setIdle();

    // Randomized traffic with occasional resets.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 600; c++) begin
      rst           = ($urandom_range(0, 99) == 0);
      bus.in_valid  = $urandom_range(0, 1) == 1;
      bus.in_data   = WIDTH'($urandom());
      bus.rd_en     = $urandom_range(0, 9) < 3;
      bus.rd_row    = IDXW'($urandom_range(0, 7));
      bus.wr_en     = $urandom_range(0, 9) < 3;
      bus.wr_row    = IDXW'($urandom_range(0, 7));
      bus.wr_data   = WIDTH'($urandom());
      bus.unload    = $urandom_range(0, 9) == 0;
      bus.out_ready = $urandom_range(0, 1) == 1;
      tick();
    end
    rst = 1'b0;
    setIdle();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
